// File: rtl/snake_move_sequencer.sv
// Snake head move-tick scheduler: divides clk into move ticks, steps the head one cell per tick
// and runs the IDLE/RUN/PAUSE/OVER game state machine. Define WRAP_AROUND_EN to wrap at walls.
module snake_move_sequencer #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int TICK_DIV = 5000000,
  parameter int START_X  = 16,
  parameter int START_Y  = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pause,
  input  logic [1:0]                direction,
  input  logic                      self_hit,
  output logic [$clog2(GRID_W)-1:0] head_x,
  output logic [$clog2(GRID_H)-1:0] head_y,
  output logic                      step,
  output logic                      game_over,
  output logic [1:0]                state
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int CW = $clog2(TICK_DIV);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [XW-1:0] X_START = XW'(START_X);
  localparam logic [YW-1:0] Y_START = YW'(START_Y);
  localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [XW-1:0] head_x_r, head_x_nxt_s, move_x_s;
  logic [YW-1:0] head_y_r, head_y_nxt_s, move_y_s;
  logic [CW-1:0] tick_cnt_r, tick_cnt_nxt_s;
  logic          step_r, step_nxt_s;
  logic          game_over_r;
  logic          terminal_s;
  logic          wall_hit_s;

  assign terminal_s = (tick_cnt_r == CNT_TOP);

  // Candidate head position one cell in the sampled direction, wrapping at the grid edges.
  always_comb begin
    move_x_s = head_x_r;
    move_y_s = head_y_r;
    case (direction)
      DIR_UP: begin
        if (head_y_r == {YW{1'b0}}) begin
          move_y_s = Y_MAX;
        end else begin
          move_y_s = head_y_r - YW'(1);
        end
      end
      DIR_DOWN: begin
        if (head_y_r == Y_MAX) begin
          move_y_s = {YW{1'b0}};
        end else begin
          move_y_s = head_y_r + YW'(1);
        end
      end
      DIR_LEFT: begin
        if (head_x_r == {XW{1'b0}}) begin
          move_x_s = X_MAX;
        end else begin
          move_x_s = head_x_r - XW'(1);
        end
      end
      DIR_RIGHT: begin
        if (head_x_r == X_MAX) begin
          move_x_s = {XW{1'b0}};
        end else begin
          move_x_s = head_x_r + XW'(1);
        end
      end
      default: begin
        move_x_s = head_x_r;
        move_y_s = head_y_r;
      end
    endcase
  end

`ifdef WRAP_AROUND_EN
  assign wall_hit_s = 1'b0;
`else
  assign wall_hit_s = ((direction == DIR_UP)    && (head_y_r == {YW{1'b0}})) ||
                      ((direction == DIR_DOWN)  && (head_y_r == Y_MAX))      ||
                      ((direction == DIR_LEFT)  && (head_x_r == {XW{1'b0}})) ||
                      ((direction == DIR_RIGHT) && (head_x_r == X_MAX));
`endif

  // Next-state logic; in RUN the order self_hit > wall > pause > tick step sets priority.
  always_comb begin
    state_nxt_s    = state_r;
    head_x_nxt_s   = head_x_r;
    head_y_nxt_s   = head_y_r;
    tick_cnt_nxt_s = tick_cnt_r;
    step_nxt_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tick_cnt_nxt_s = {CW{1'b0}};
        if (start) begin
          state_nxt_s  = ST_RUN;
          head_x_nxt_s = X_START;
          head_y_nxt_s = Y_START;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (self_hit) begin
          state_nxt_s = ST_OVER;
        end else if (terminal_s && wall_hit_s) begin
          state_nxt_s = ST_OVER;
        end else if (pause) begin
          state_nxt_s = ST_PAUSE;
        end else if (terminal_s) begin
          tick_cnt_nxt_s = {CW{1'b0}};
          head_x_nxt_s   = move_x_s;
          head_y_nxt_s   = move_y_s;
          step_nxt_s     = 1'b1;
        end else begin
          tick_cnt_nxt_s = tick_cnt_r + CW'(1);
        end
      end
      ST_PAUSE: begin
        // Counter stays frozen here; counting restarts from the held value once back in RUN.
        if (!pause) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_OVER: begin
        if (start) begin
          state_nxt_s    = ST_RUN;
          head_x_nxt_s   = X_START;
          head_y_nxt_s   = Y_START;
          tick_cnt_nxt_s = {CW{1'b0}};
        end else begin
          state_nxt_s    = ST_OVER;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        tick_cnt_nxt_s = {CW{1'b0}};
      end
    endcase
  end

  // State, head, tick counter and registered strobes with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      head_x_r    <= X_START;
      head_y_r    <= Y_START;
      tick_cnt_r  <= {CW{1'b0}};
      step_r      <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      head_x_r    <= head_x_nxt_s;
      head_y_r    <= head_y_nxt_s;
      tick_cnt_r  <= tick_cnt_nxt_s;
      step_r      <= step_nxt_s;
      game_over_r <= (state_nxt_s == ST_OVER);
    end
  end

  assign head_x    = head_x_r;
  assign head_y    = head_y_r;
  assign step      = step_r;
  assign game_over = game_over_r;
  assign state     = state_r;

endmodule

// File: tb/tb_snake_move_sequencer.sv
// Scoreboard bench for snake_move_sequencer: a cycle-level game model predicts each edge's
// outputs into queues that an independent monitor pops and compares.
module tb_snake_move_sequencer;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int TD = 4;
  localparam int SX = 4;
  localparam int SY = 4;
`ifdef WRAP_AROUND_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, pause, self_hit;
  logic [1:0] direction;
  logic [2:0] head_x, head_y;
  logic       step, game_over;
  logic [1:0] state;

  typedef struct {
    int st;
    int x;
    int y;
    bit stp;
    bit go;
  } snap_t;

  snap_t exp_q[$];
  int    step_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    armed  = 1'b0;
  int    cyc    = 0;
  int    m_st, m_x, m_y, m_cnt;

  snake_move_sequencer #(
    .GRID_W(W), .GRID_H(H), .TICK_DIV(TD), .START_X(SX), .START_Y(SY)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .direction(direction),
    .self_hit(self_hit), .head_x(head_x), .head_y(head_y), .step(step),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  // Game rules: states 0 idle, 1 run, 2 pause, 3 over; a move happens on every TD-th run cycle.
  task automatic model_edge(input bit r, input bit s, input bit p, input int d, input bit sh);
    int dx, dy, nx, ny;
    bit off, stp;
    dx = 0; dy = 0; stp = 1'b0;
    if (d == 0) dy = -1;
    else if (d == 1) dy = 1;
    else if (d == 2) dx = -1;
    else dx = 1;
    nx = m_x + dx;
    ny = m_y + dy;
    off = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
    if (r) begin
      m_st = 0; m_x = SX; m_y = SY; m_cnt = 0;
    end else if (m_st == 0 || m_st == 3) begin
      if (s) begin
        m_st = 1; m_x = SX; m_y = SY; m_cnt = 0;
      end
    end else if (m_st == 1) begin
      if (sh) m_st = 3;
      else if (m_cnt == TD - 1 && off && !WRAP) m_st = 3;
      else if (p) m_st = 2;
      else if (m_cnt == TD - 1) begin
        m_cnt = 0;
        m_x = (nx + W) % W;
        m_y = (ny + H) % H;
        stp = 1'b1;
        step_q.push_back(m_x * 16 + m_y);
      end else m_cnt++;
    end else begin
      if (!p) m_st = 1;
    end
    exp_q.push_back('{m_st, m_x, m_y, stp, (m_st == 3)});
    armed = 1'b1;
  endtask

  task automatic drive(input bit r, input bit s, input bit p, input logic [1:0] d, input bit sh);
    @(negedge clk);
    reset = r; start = s; pause = p; direction = d; self_hit = sh;
    model_edge(r, s, p, int'(d), sh);
  endtask

  // Monitor: after every edge pop the predicted snapshot; on each step strobe pop the move.
  initial begin
    snap_t e;
    int    v;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (state !== 2'(e.st) || head_x !== 3'(e.x) || head_y !== 3'(e.y) ||
            step !== e.stp || game_over !== e.go) begin
          errors++;
          $display("FAIL status cyc=%0d got st=%0d x=%0d y=%0d step=%0b go=%0b want st=%0d x=%0d y=%0d step=%0b go=%0b",
                   cyc, state, head_x, head_y, step, game_over, e.st, e.x, e.y, e.stp, e.go);
        end
        if (step === 1'b1) begin
          checks++;
          if (step_q.size() == 0) begin
            errors++;
            $display("FAIL step_unexpected cyc=%0d got head=(%0d,%0d) want no step", cyc, head_x, head_y);
          end else begin
            v = step_q.pop_front();
            if (head_x !== 3'(v / 16) || head_y !== 3'(v % 16)) begin
              errors++;
              $display("FAIL step_head cyc=%0d got (%0d,%0d) want (%0d,%0d)", cyc, head_x, head_y, v / 16, v % 16);
            end
          end
        end
      end else if (armed) begin
        checks++;
        errors++;
        $display("FAIL underflow cyc=%0d got output with no prediction want prediction", cyc);
      end
    end
  end

  initial begin
    int  guard;
    bit  p_lvl;
    reset = 1'b1; start = 1'b0; pause = 1'b0; direction = 2'b11; self_hit = 1'b0;
    m_st = 0; m_x = SX; m_y = SY; m_cnt = 0;
    repeat (3) drive(1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
    // Run right to the wall: steps at +4, +8, +12, wall at +16.
    drive(1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    repeat (16) drive(1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
    // pause/self_hit ignored in OVER, then restart and pause at tick_cnt 2.
    repeat (3) drive(1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (10) drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    repeat (6) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    // self_hit coinciding with terminal count.
    guard = 0;
    while (m_st == 1 && m_cnt != TD - 1 && guard < 10) begin
      drive(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
      guard++;
    end
    drive(1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    // Restart from OVER, then reset while paused at tick_cnt 3.
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
    guard = 0;
    while (m_st == 1 && m_cnt != TD - 1 && guard < 10) begin
      drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
      guard++;
    end
    repeat (3) drive(1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    repeat (20) drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    // Randomized play.
    p_lvl = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) p_lvl = ~p_lvl;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, p_lvl,
            2'($urandom_range(0, 3)), $urandom_range(0, 59) == 0);
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || step_q.size() != 0) begin
      errors++;
      $display("FAIL drain got status=%0d steps=%0d pending want 0 and 0", exp_q.size(), step_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
